// File: rtl/flags_pkg.sv
// Shared constants and types for the NZCV status register and condition evaluation.
package flags_pkg;

    localparam int unsigned FLAGS_W    = 4;
    localparam int unsigned COND_W     = 4;
    localparam int unsigned CTRL_W     = 4;

    localparam int unsigned FLAG_Z     = 3;
    localparam int unsigned FLAG_N     = 2;
    localparam int unsigned FLAG_C     = 1;
    localparam int unsigned FLAG_V     = 0;

    localparam int unsigned CTRL_SUB   = 0;
    localparam int unsigned CTRL_LOGIC = 1;

    typedef enum logic [COND_W-1:0] {
        EQ, NE, CS, CC, MI, PL, VS, VC,
        HI, LS, GE, LT, GT, LE, AL, NV
    } cond_e;

    // Bit order matches the FLAGS bus: {Z,N,C,V}
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/flags_status_reg_cond_eval.sv
// ARM-style condition-code evaluation of a 4-bit {Z,N,C,V} flag set; purely combinational.
module cond_eval
    import flags_pkg::*;
(
    input  logic [FLAGS_W-1:0] flags_i,
    input  logic [COND_W-1:0]  cond_i,
    output logic               pass_o
);

    flags_t f;
    assign f = flags_t'(flags_i);

    always_comb begin
        pass_o = 1'b0;
        case (cond_e'(cond_i))
            EQ: pass_o = f.z;
            NE: pass_o = ~f.z;
            CS: pass_o = f.c;
            CC: pass_o = ~f.c;
            MI: pass_o = f.n;
            PL: pass_o = ~f.n;
            VS: pass_o = f.v;
            VC: pass_o = ~f.v;
            HI: pass_o = f.c & ~f.z;
            LS: pass_o = ~f.c | f.z;
            GE: pass_o = (f.n == f.v);
            LT: pass_o = (f.n != f.v);
            GT: pass_o = ~f.z & (f.n == f.v);
            LE: pass_o = f.z | (f.n != f.v);
            AL: pass_o = 1'b1;
            NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flags_status_reg.sv
// Registered NZCV status register with sticky C/V, saturating overflow counter,
// flag restore port and condition-code evaluation on the registered flags.
module flags_status_reg
    import flags_pkg::*;
#(
    parameter int unsigned N_b         = 32,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned PRESERVE_CV = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_b-1:0]     A,
    input  logic [N_b-1:0]     B,
    input  logic [N_b-1:0]     SUM,
    input  logic [N_b-1:0]     result,
    input  logic               Cout,
    input  logic [CTRL_W-1:0]  ALUControl,
    input  logic               in_valid,
    input  logic               set_flags,
    input  logic               flag_wr,
    input  logic [FLAGS_W-1:0] flag_wdata,
    input  logic               clear_sticky,
    input  logic [COND_W-1:0]  cond,
    output logic [FLAGS_W-1:0] FLAGS,
    output logic               cond_pass,
    output logic               out_valid,
    output logic               sticky_v,
    output logic               sticky_c,
    output logic [CNT_W-1:0]   ovf_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    flags_t           flags_q, flags_d, flags_n;
    logic             out_valid_q, out_valid_d;
    logic             sticky_v_q, sticky_v_d;
    logic             sticky_c_q, sticky_c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture;
    logic             is_logic;

    // Only the msb of the operands/sum and the low control bits feed the flags
    logic unused_inputs;
    assign unused_inputs = ^{A[N_b-2:0], B[N_b-2:0], SUM[N_b-2:0], ALUControl[CTRL_W-1:2]};

    assign capture  = in_valid & set_flags & ~flag_wr;
    assign is_logic = ALUControl[CTRL_LOGIC];

    // Candidate flags from the datapath, with C/V optionally held across logic ops
    always_comb begin
        flags_n.z = (result == '0);
        flags_n.n = result[N_b-1];
        flags_n.c = ~is_logic & Cout;
        flags_n.v = ~(ALUControl[CTRL_SUB] ^ A[N_b-1] ^ B[N_b-1])
                    & (A[N_b-1] ^ SUM[N_b-1]) & ~is_logic;
        if ((PRESERVE_CV != 0) && is_logic) begin
            flags_n.c = flags_q.c;
            flags_n.v = flags_q.v;
        end
    end

    // Next-state: restore beats capture; clear_sticky applies before a same-cycle capture
    always_comb begin
        flags_d     = flags_q;
        out_valid_d = capture | flag_wr;
        sticky_v_d  = sticky_v_q;
        sticky_c_d  = sticky_c_q;
        cnt_d       = cnt_q;

        if (flag_wr) begin
            flags_d = flags_t'(flag_wdata);
        end else if (capture) begin
            flags_d = flags_n;
        end

        if (clear_sticky) begin
            sticky_v_d = 1'b0;
            sticky_c_d = 1'b0;
            cnt_d      = '0;
        end

        if (capture) begin
            sticky_v_d = sticky_v_d | flags_n.v;
            sticky_c_d = sticky_c_d | flags_n.c;
            if (flags_n.v && (cnt_d != CNT_MAX)) begin
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            sticky_v_q  <= 1'b0;
            sticky_c_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            sticky_v_q  <= sticky_v_d;
            sticky_c_q  <= sticky_c_d;
            cnt_q       <= cnt_d;
        end
    end

    assign FLAGS     = flags_q;
    assign out_valid = out_valid_q;
    assign sticky_v  = sticky_v_q;
    assign sticky_c  = sticky_c_q;
    assign ovf_count = cnt_q;

    cond_eval u_cond_eval (
        .flags_i (flags_q),
        .cond_i  (cond),
        .pass_o  (cond_pass)
    );

endmodule
